// File: rtl/pulse_period_meter.sv
// Measures cycles between rising edges of pulse_in; results visible one cycle after the edge's posedge.
// No backpressure: period_valid is a one-cycle strobe that the consumer must capture when it fires.
module pulse_period_meter #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8,
    parameter int TIMEOUT   = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 pulse_in,
    output logic [WIDTH-1:0]     period,
    output logic                 period_valid,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] edge_count,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_MEASURE,
        ST_TMO
    } state_t;

    localparam logic [WIDTH-1:0] TO_LIMIT = WIDTH'(TIMEOUT);

    state_t               state, state_nxt;
    logic                 prev;
    logic                 edge_det;
    logic [WIDTH-1:0]     cnt, cnt_nxt;
    logic [WIDTH-1:0]     period_nxt;
    logic                 valid_nxt;
    logic                 timeout_nxt;
    logic [CNT_WIDTH-1:0] edge_count_nxt;

    assign edge_det = pulse_in & ~prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            prev         <= 1'b0;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            edge_count   <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            prev         <= pulse_in;
            cnt          <= cnt_nxt;
            period       <= period_nxt;
            period_valid <= valid_nxt;
            timeout      <= timeout_nxt;
            edge_count   <= edge_count_nxt;
            busy         <= (state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        period_nxt     = period;
        valid_nxt      = 1'b0;
        timeout_nxt    = timeout;
        edge_count_nxt = edge_count;

        case (state)
            ST_IDLE: begin
                // An edge coincident with arming (e.g. pulse_in already high at
                // reset release) is taken as the first edge rather than lost.
                if (en) begin
                    if (edge_det) begin
                        state_nxt      = ST_MEASURE;
                        cnt_nxt        = WIDTH'(1);
                        edge_count_nxt = CNT_WIDTH'(1);
                    end else begin
                        state_nxt      = ST_ARMED;
                        edge_count_nxt = '0;
                    end
                end
            end
            ST_ARMED: begin
                if (!en) begin
                    state_nxt   = ST_IDLE;
                    cnt_nxt     = '0;
                    timeout_nxt = 1'b0;
                end else if (edge_det) begin
                    state_nxt      = ST_MEASURE;
                    cnt_nxt        = WIDTH'(1);
                    edge_count_nxt = edge_count + 1'b1;
                end
            end
            ST_MEASURE: begin
                if (!en) begin
                    state_nxt   = ST_IDLE;
                    cnt_nxt     = '0;
                    timeout_nxt = 1'b0;
                end else if (edge_det) begin
                    period_nxt     = cnt;
                    valid_nxt      = 1'b1;
                    cnt_nxt        = WIDTH'(1);
                    edge_count_nxt = edge_count + 1'b1;
                end else if (cnt == TO_LIMIT) begin
                    state_nxt   = ST_TMO;
                    timeout_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_TMO: begin
                if (!en) begin
                    state_nxt   = ST_IDLE;
                    cnt_nxt     = '0;
                    timeout_nxt = 1'b0;
                end else if (edge_det) begin
                    state_nxt      = ST_MEASURE;
                    cnt_nxt        = WIDTH'(1);
                    edge_count_nxt = edge_count + 1'b1;
                    timeout_nxt    = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: directed interval table, timeout/enable/reset sequences, then random pulse trains.
module tb_pulse_period_meter;

    localparam int WIDTH     = 16;
    localparam int CNT_WIDTH = 8;
    localparam int TIMEOUT   = 20;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic                 pulse_in;
    logic [WIDTH-1:0]     period;
    logic                 period_valid;
    logic                 timeout;
    logic [CNT_WIDTH-1:0] edge_count;
    logic                 busy;

    pulse_period_meter #(
        .WIDTH    (WIDTH),
        .CNT_WIDTH(CNT_WIDTH),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pulse_in    (pulse_in),
        .period      (period),
        .period_valid(period_valid),
        .timeout     (timeout),
        .edge_count  (edge_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: tracks the time of the last edge rather than a counter.
    bit m_active, m_to, m_vld, m_prev;
    int m_ref, m_per, m_ecnt, t;

    typedef struct {
        int gap;
        int exp_per;
        bit exp_vld;
        int exp_ecnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, act, exp, t);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_to     = 1'b0;
        m_vld    = 1'b0;
        m_prev   = 1'b0;
        m_ref    = -1;
        m_per    = 0;
        m_ecnt   = 0;
    endtask

    task automatic model_step(input bit e_n, input bit p);
        bit e;
        e      = p && !m_prev;
        m_prev = p;
        m_vld  = 1'b0;
        if (!m_active) begin
            if (e_n) begin
                m_active = 1'b1;
                m_to     = 1'b0;
                m_ecnt   = e ? 1 : 0;
                m_ref    = e ? t : -1;
            end
        end else if (!e_n) begin
            m_active = 1'b0;
            m_ref    = -1;
            m_to     = 1'b0;
        end else if (e) begin
            if (m_ref >= 0 && !m_to) begin
                m_per = t - m_ref;
                m_vld = 1'b1;
            end
            m_ecnt = (m_ecnt + 1) % (1 << CNT_WIDTH);
            m_ref  = t;
            m_to   = 1'b0;
        end else if (m_ref >= 0 && !m_to && (t - m_ref) == TIMEOUT) begin
            m_to = 1'b1;
        end
    endtask

    task automatic tick(input bit e_n, input bit p);
        en       = e_n;
        pulse_in = p;
        @(posedge clk);
        t++;
        #1;
        model_step(e_n, p);
        chk("model_period",  period,       m_per);
        chk("model_valid",   period_valid, m_vld);
        chk("model_timeout", timeout,      m_to);
        chk("model_ecount",  edge_count,   m_ecnt);
        chk("model_busy",    busy,         m_active);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_period"},  period,       0);
        chk({tag, "_valid"},   period_valid, 0);
        chk({tag, "_timeout"}, timeout,      0);
        chk({tag, "_ecount"},  edge_count,   0);
        chk({tag, "_busy"},    busy,         0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gap, hi_len, pos, en_low;

        tbl.push_back('{3,  0,  1'b0, 1});
        tbl.push_back('{10, 10, 1'b1, 2});
        tbl.push_back('{10, 10, 1'b1, 3});
        tbl.push_back('{10, 10, 1'b1, 4});
        tbl.push_back('{5,  5,  1'b1, 5});
        tbl.push_back('{7,  7,  1'b1, 6});
        tbl.push_back('{3,  3,  1'b1, 7});
        tbl.push_back('{2,  2,  1'b1, 8});

        t        = 0;
        rst      = 1'b0;
        en       = 1'b0;
        pulse_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;

        tick(1'b1, 1'b0);
        chk("arm_busy",   busy,       1);
        chk("arm_ecount", edge_count, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            for (int j = 0; j < tbl[i].gap - 1; j++) tick(1'b1, 1'b0);
            tick(1'b1, 1'b1);
            chk($sformatf("tbl%0d_period", i), period,       tbl[i].exp_per);
            chk($sformatf("tbl%0d_valid", i),  period_valid, tbl[i].exp_vld);
            chk($sformatf("tbl%0d_ecount", i), edge_count,   tbl[i].exp_ecnt);
        end
        tick(1'b1, 1'b0);
        chk("strobe_drop_valid",  period_valid, 0);
        chk("strobe_drop_period", period,       2);

        // Enable drop mid-measurement, with a coincident edge that must be ignored.
        for (int j = 0; j < 8; j++) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        chk("pre_en_period", period, 10);
        repeat (3) tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        chk("en_off_busy",    busy,         0);
        chk("en_off_timeout", timeout,      0);
        chk("en_off_period",  period,       10);
        chk("en_off_valid",   period_valid, 0);
        chk("en_off_ecount",  edge_count,   9);
        tick(1'b1, 1'b0);
        chk("rearm_busy",   busy,       1);
        chk("rearm_ecount", edge_count, 0);

        // Timeout after silence, then recovery.
        tick(1'b1, 1'b1);
        chk("to_first_ecount", edge_count,   1);
        chk("to_first_valid",  period_valid, 0);
        repeat (19) tick(1'b1, 1'b0);
        chk("to_before", timeout, 0);
        tick(1'b1, 1'b0);
        chk("to_at",        timeout,      1);
        chk("to_at_valid",  period_valid, 0);
        chk("to_at_period", period,       10);
        repeat (4) tick(1'b1, 1'b0);
        chk("to_hold", timeout, 1);
        tick(1'b1, 1'b1);
        chk("to_exit_timeout", timeout,      0);
        chk("to_exit_valid",   period_valid, 0);
        chk("to_exit_ecount",  edge_count,   2);
        repeat (5) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        chk("after_to_period", period,       6);
        chk("after_to_valid",  period_valid, 1);

        // Edge exactly at the timeout limit wins.
        repeat (19) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        chk("limit_period",  period,       20);
        chk("limit_valid",   period_valid, 1);
        chk("limit_timeout", timeout,      0);
        chk("limit_ecount",  edge_count,   4);
        tick(1'b1, 1'b0);
        chk("limit_next_timeout", timeout, 0);

        // Asynchronous reset mid-measurement.
        repeat (2) tick(1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        en       = 1'b1;
        pulse_in = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("rst_held");
        rst = 1'b1;
        model_reset();
        tick(1'b1, 1'b1);
        chk("release_edge_ecount", edge_count,   1);
        chk("release_edge_busy",   busy,         1);
        chk("release_edge_valid",  period_valid, 0);

        // Edge counter wrap.
        for (int i = 0; i < 255; i++) begin
            tick(1'b1, 1'b0);
            tick(1'b1, 1'b1);
        end
        chk("wrap_ecount", edge_count,   0);
        chk("wrap_period", period,       2);
        chk("wrap_valid",  period_valid, 1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        chk("wrap_next_ecount", edge_count, 1);

        // Random pulse trains with occasional enable drops.
        pos    = 0;
        gap    = 0;
        hi_len = 0;
        en_low = 0;
        for (int c = 0; c < 5000; c++) begin
            bit p_r, e_r;
            if (pos >= gap) begin
                gap    = $urandom_range(2, 26);
                hi_len = $urandom_range(1, gap - 1);
                pos    = 0;
            end
            p_r = (pos < hi_len);
            pos++;
            if (en_low > 0) begin
                en_low--;
                e_r = 1'b0;
            end else if ($urandom_range(0, 149) == 0) begin
                en_low = $urandom_range(0, 3);
                e_r    = 1'b0;
            end else begin
                e_r = 1'b1;
            end
            tick(e_r, p_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
- Receive-side companion to the team's enable-gated `counter`.
- Consumes a single-bit pulse stream on the same clock, such as the counter's `out_p`, and measures the interval in clock cycles between consecutive rising edges.
- Reports each interval with a one-cycle valid strobe, counts edges, and flags a missing-pulse timeout.
- Sits downstream of pulse generators as a self-check and monitor block.

Parameters:
- WIDTH, 16, width of the period measurement and internal interval counter.
- CNT_WIDTH, 8, width of the edge counter.
- TIMEOUT, 1000, interval in cycles without an edge that declares timeout; legal range is 2 to 2^WIDTH-1.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  measurement enable; level-sensitive.
- pulse_in  input  1  pulse stream, synchronous to clk; no synchronizer.
- period  output  WIDTH  last measured interval in cycles.
- period_valid  output  1  one-cycle strobe marking that period was updated.
- timeout  output  1  high while in TIMEOUT state.
- edge_count  output  CNT_WIDTH  rising edges seen since arming; wraps modulo 2^CNT_WIDTH.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - period, period_valid, timeout, edge_count, busy and the internal counter cnt are all 0.
  - The edge-detect register prev is 0.
  - Release is sampled synchronously at the next clk edge.
- Edge detect:
  - edge = pulse_in & ~prev, evaluated at each posedge.
  - prev <= pulse_in on every cycle, in every state.
  - pulse_in already high at reset release counts as an edge if en is high.
- All outputs are registered. Event timing: an edge at posedge k is visible on outputs after posedge k.
- IDLE:
  - Edges are ignored.
  - On en=1, go to ARMED and clear edge_count to 0.
- ARMED:
  - On edge, go to MEASURE with cnt=1 and edge_count+1.
  - No period is reported for the first edge.
- MEASURE:
  - Without an edge, cnt+1 each cycle.
  - On edge at posedge k (previous edge at k0):
    - period <= k-k0, which equals the current cnt.
    - period_valid=1 for exactly one cycle.
    - cnt <= 1, edge_count+1.
  - Back-to-back edges cannot occur; each edge requires a low cycle between, so the minimum period is 2.
- Timeout:
  - If cnt == TIMEOUT and there is no edge this cycle, go to TIMEOUT.
  - timeout <= 1, period_valid stays 0, period is retained.
- Simultaneous edge and cnt == TIMEOUT: the edge wins. period = TIMEOUT is reported with a valid strobe and the block stays in MEASURE.
- TIMEOUT state:
  - cnt holds.
  - On edge, go to MEASURE with cnt=1, edge_count+1, timeout <= 0.
  - That edge is treated as a fresh first edge; no period is reported.
- en=0 in any non-IDLE state:
  - Go to IDLE at the next posedge; cnt=0, timeout=0, period_valid=0.
  - period and edge_count are retained.
  - An edge in that same cycle is ignored.
- busy = (state != IDLE), registered with the state.
- Reset asserted mid-measurement: all outputs clear immediately, without waiting for clk.
- Widths:
  - cnt is WIDTH bits and never exceeds TIMEOUT.
  - edge_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.

Test Plan:
1. Drive rst=0 for 2 cycles, en=1, then `counter` pulses every 10 cycles → first edge gives no strobe; every later edge gives period=10 and period_valid high for 1 cycle; edge_count = 1, 2, 3, ...
2. Pulses at intervals 5, 7, 3 → period strobes 5, 7, 3 in order; edge_count=4 after the fourth edge.
3. TIMEOUT=20; one edge, then silence → timeout=1 exactly 20 cycles after the edge with no strobe. Next edge → timeout=0 and no strobe; edge after 6 more cycles → period=6.
4. TIMEOUT=20; second edge exactly 20 cycles after the first → period=20, valid strobe, timeout stays 0.
5. en drops mid-measurement (cnt=4), period=10 retained → busy=0 next cycle, timeout=0, period=10. Re-raising en → edge_count=0, ARMED.
6. rst asserted between clk edges during MEASURE → outputs 0 immediately. After release with en=1 and pulse_in held high → first posedge counts as edge, edge_count=1.
